// File: rtl/stopwatch_pkg.sv
// Shared definitions for the stopwatch core: FSM encoding, BCD digit
// limits and the single-digit increment helper.
package stopwatch_pkg;

  typedef enum logic [1:0] {
    ST_ZERO = 2'd0,
    ST_RUN  = 2'd1,
    ST_STOP = 2'd2
  } sw_state_e;

  localparam logic [3:0] BCD_MAX9 = 4'd9;
  localparam logic [3:0] BCD_MAX5 = 4'd5;

  // Next value of a BCD digit that counts 0..max and wraps to zero.
  // Anything at or above max (including illegal codes) goes to zero,
  // so a corrupted digit scrubs itself on its next increment.
  function automatic logic [3:0] bcd_next(input logic [3:0] dig,
                                          input logic [3:0] max);
    logic [3:0] nxt;
    if (dig >= max) begin
      nxt = 4'd0;
    end else begin
      nxt = dig + 4'd1;
    end
    return nxt;
  endfunction

endpackage

// File: rtl/stopwatch_core_bcd_digit.sv
// One BCD digit of the stopwatch chain: synchronous clear, increment with
// wrap at MAX, and a combinational carry to the next more significant digit.
module bcd_digit
  import stopwatch_pkg::*;
(
  input  logic       I_CLK,
  input  logic       I_RSTN,
  input  logic       I_CLR,
  input  logic       I_INC,
  input  logic [3:0] MAX,
  output logic [3:0] O_DIG,
  output logic       O_CARRY
);

  logic [3:0] dig_q;
  logic [3:0] dig_d;

  // Next digit value: clear wins, then increment, otherwise hold
  // (an out-of-range code is forced back to zero instead of held).
  always_comb begin
    dig_d = dig_q;
    if (I_CLR) begin
      dig_d = 4'd0;
    end else if (I_INC) begin
      dig_d = bcd_next(dig_q, MAX);
    end else if (dig_q > MAX) begin
      dig_d = 4'd0;
    end else begin
      dig_d = dig_q;
    end
  end

  // Digit register with asynchronous reset to zero.
  always_ff @(posedge I_CLK or negedge I_RSTN) begin
    if (!I_RSTN) begin
      dig_q <= 4'd0;
    end else begin
      dig_q <= dig_d;
    end
  end

  assign O_DIG   = dig_q;
  assign O_CARRY = I_INC & (dig_q == MAX);

endmodule

// File: rtl/stopwatch_core.sv
// Stopwatch core: run/stop/clear FSM, 10 ms prescaler and a six-digit
// BCD cascade producing MM:SS.cc, with a one-cycle pulse on full wrap.
module stopwatch_core
  import stopwatch_pkg::*;
#(
  parameter int TICK_DIV = 160000,
  parameter int DIV_W    = 18
) (
  input  logic       I_CLK,
  input  logic       I_RSTN,
  input  logic       I_START_EN,
  input  logic       I_CLR_EN,
  output logic [3:0] O_CS_ONE,
  output logic [3:0] O_CS_TEN,
  output logic [3:0] O_SEC_ONE,
  output logic [3:0] O_SEC_TEN,
  output logic [3:0] O_MIN_ONE,
  output logic [3:0] O_MIN_TEN,
  output logic       O_RUN,
  output logic       O_OVF
);

  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(TICK_DIV - 1);
  localparam logic [DIV_W-1:0] DIV_ONE  = {{(DIV_W-1){1'b0}}, 1'b1};

  sw_state_e        state_q;
  logic             run_q;
  logic             ovf_q;
  logic [DIV_W-1:0] div_q;
  logic [DIV_W-1:0] div_d;

  logic             run_en_s;
  logic             tick_s;
  logic             ovf_d;
  logic             cy_cs_one_s;
  logic             cy_cs_ten_s;
  logic             cy_sec_one_s;
  logic             cy_sec_ten_s;
  logic             cy_min_one_s;
  logic             cy_min_ten_s;

  // Clear overrides run; the tick fires on the edge the prescaler wraps.
  assign run_en_s = I_START_EN & ~I_CLR_EN;
  assign tick_s   = run_en_s & (div_q == DIV_LAST);

  // Prescaler next value: cleared with the digits, advanced only while
  // enabled, held otherwise so a resume continues the partial tick.
  always_comb begin
    div_d = div_q;
    if (I_CLR_EN) begin
      div_d = {DIV_W{1'b0}};
    end else if (run_en_s) begin
      if (tick_s) begin
        div_d = {DIV_W{1'b0}};
      end else begin
        div_d = div_q + DIV_ONE;
      end
    end else begin
      div_d = div_q;
    end
  end

  // Overflow pulse: set on the edge the whole chain rolls over to zero.
  always_comb begin
    ovf_d = 1'b0;
    if (tick_s && cy_min_ten_s) begin
      ovf_d = 1'b1;
    end else begin
      ovf_d = 1'b0;
    end
  end

  // Prescaler and overflow registers.
  always_ff @(posedge I_CLK or negedge I_RSTN) begin
    if (!I_RSTN) begin
      div_q <= {DIV_W{1'b0}};
      ovf_q <= 1'b0;
    end else begin
      div_q <= div_d;
      ovf_q <= ovf_d;
    end
  end

  // Run/stop/clear FSM with registered run flag; clear has top priority.
  always_ff @(posedge I_CLK or negedge I_RSTN) begin
    if (!I_RSTN) begin
      state_q <= ST_ZERO;
      run_q   <= 1'b0;
    end else if (I_CLR_EN) begin
      state_q <= ST_ZERO;
      run_q   <= 1'b0;
    end else if (I_START_EN) begin
      state_q <= ST_RUN;
      run_q   <= 1'b1;
    end else begin
      case (state_q)
        ST_ZERO: state_q <= ST_ZERO;
        ST_RUN:  state_q <= ST_STOP;
        ST_STOP: state_q <= ST_STOP;
        default: state_q <= ST_ZERO;
      endcase
      run_q <= 1'b0;
    end
  end

  bcd_digit u_cs_one (
    .I_CLK   (I_CLK),
    .I_RSTN  (I_RSTN),
    .I_CLR   (I_CLR_EN),
    .I_INC   (tick_s),
    .MAX     (BCD_MAX9),
    .O_DIG   (O_CS_ONE),
    .O_CARRY (cy_cs_one_s)
  );

  bcd_digit u_cs_ten (
    .I_CLK   (I_CLK),
    .I_RSTN  (I_RSTN),
    .I_CLR   (I_CLR_EN),
    .I_INC   (cy_cs_one_s),
    .MAX     (BCD_MAX9),
    .O_DIG   (O_CS_TEN),
    .O_CARRY (cy_cs_ten_s)
  );

  bcd_digit u_sec_one (
    .I_CLK   (I_CLK),
    .I_RSTN  (I_RSTN),
    .I_CLR   (I_CLR_EN),
    .I_INC   (cy_cs_ten_s),
    .MAX     (BCD_MAX9),
    .O_DIG   (O_SEC_ONE),
    .O_CARRY (cy_sec_one_s)
  );

  bcd_digit u_sec_ten (
    .I_CLK   (I_CLK),
    .I_RSTN  (I_RSTN),
    .I_CLR   (I_CLR_EN),
    .I_INC   (cy_sec_one_s),
    .MAX     (BCD_MAX5),
    .O_DIG   (O_SEC_TEN),
    .O_CARRY (cy_sec_ten_s)
  );

  bcd_digit u_min_one (
    .I_CLK   (I_CLK),
    .I_RSTN  (I_RSTN),
    .I_CLR   (I_CLR_EN),
    .I_INC   (cy_sec_ten_s),
    .MAX     (BCD_MAX9),
    .O_DIG   (O_MIN_ONE),
    .O_CARRY (cy_min_one_s)
  );

  bcd_digit u_min_ten (
    .I_CLK   (I_CLK),
    .I_RSTN  (I_RSTN),
    .I_CLR   (I_CLR_EN),
    .I_INC   (cy_min_one_s),
    .MAX     (BCD_MAX5),
    .O_DIG   (O_MIN_TEN),
    .O_CARRY (cy_min_ten_s)
  );

  assign O_RUN = run_q;
  assign O_OVF = ovf_q;

endmodule

// File: tb/tb_stopwatch_core.sv
// Bench for stopwatch_core: elapsed-time model in plain centisecond
// arithmetic, checked every cycle, plus hand-computed literal checkpoints.
module tb_stopwatch_core;

  localparam int TD    = 4;
  localparam int T_MAX = 359999;

  logic       clk = 1'b0;
  logic       rst_n = 1'b1;
  logic       start = 1'b0;
  logic       clr = 1'b0;
  logic [3:0] cs_one, cs_ten, sec_one, sec_ten, min_one, min_ten;
  logic       run_o, ovf_o;
  logic [23:0] act_dig;

  // model state: total elapsed centiseconds, enabled edges into the current tick
  int   m_total = 0;
  int   m_phase = 0;
  logic m_run = 1'b0;
  logic m_ovf = 1'b0;
  logic pre_req = 1'b0;

  logic        chk_en = 1'b0;
  logic        lit_en = 1'b0;
  logic [23:0] lit_dig = 24'h0;
  logic        lit_run = 1'b0;
  logic        lit_ovf = 1'b0;
  string       lit_name = "";

  int n_vec = 0;
  int n_bad = 0;

  stopwatch_core #(.TICK_DIV(TD), .DIV_W(4)) dut (
    .I_CLK      (clk),
    .I_RSTN     (rst_n),
    .I_START_EN (start),
    .I_CLR_EN   (clr),
    .O_CS_ONE   (cs_one),
    .O_CS_TEN   (cs_ten),
    .O_SEC_ONE  (sec_one),
    .O_SEC_TEN  (sec_ten),
    .O_MIN_ONE  (min_one),
    .O_MIN_TEN  (min_ten),
    .O_RUN      (run_o),
    .O_OVF      (ovf_o)
  );

  always #5 clk = ~clk;

  assign act_dig = {min_ten, min_one, sec_ten, sec_one, cs_ten, cs_one};

  // MM:SS.cc as packed BCD from a centisecond total
  function automatic logic [23:0] to_bcd(input int t);
    int mm, ss, cc;
    mm = t / 6000;
    ss = (t / 100) % 60;
    cc = t % 100;
    return {4'(mm / 10), 4'(mm % 10), 4'(ss / 10), 4'(ss % 10),
            4'(cc / 10), 4'(cc % 10)};
  endfunction

  // elapsed-time model
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_total <= 0; m_phase <= 0; m_run <= 1'b0; m_ovf <= 1'b0;
    end else if (pre_req) begin
      m_total <= T_MAX; m_run <= 1'b0; m_ovf <= 1'b0;
    end else if (clr) begin
      m_total <= 0; m_phase <= 0; m_run <= 1'b0; m_ovf <= 1'b0;
    end else if (start) begin
      m_run <= 1'b1;
      if (m_phase + 1 == TD) begin
        m_phase <= 0;
        if (m_total == T_MAX) begin
          m_total <= 0; m_ovf <= 1'b1;
        end else begin
          m_total <= m_total + 1; m_ovf <= 1'b0;
        end
      end else begin
        m_phase <= m_phase + 1; m_ovf <= 1'b0;
      end
    end else begin
      m_run <= 1'b0; m_ovf <= 1'b0;
    end
  end

  // single compare process: model every cycle, literal checkpoint when armed
  always @(negedge clk) begin
    if (chk_en) begin
      n_vec++;
      if (act_dig !== to_bcd(m_total) || run_o !== m_run || ovf_o !== m_ovf) begin
        n_bad++;
        $display("FAIL model @%0t: got %h run=%b ovf=%b, expected %h run=%b ovf=%b",
                 $time, act_dig, run_o, ovf_o, to_bcd(m_total), m_run, m_ovf);
      end
    end
    if (lit_en) begin
      n_vec++;
      if (act_dig !== lit_dig || run_o !== lit_run || ovf_o !== lit_ovf) begin
        n_bad++;
        $display("FAIL %s @%0t: got %h run=%b ovf=%b, expected %h run=%b ovf=%b",
                 lit_name, $time, act_dig, run_o, ovf_o, lit_dig, lit_run, lit_ovf);
      end
    end
  end

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic lit(input string name, input logic [23:0] d,
                     input logic r, input logic o);
    lit_name = name; lit_dig = d; lit_run = r; lit_ovf = o; lit_en = 1'b1;
    @(negedge clk);
    #1;
    lit_en = 1'b0;
  endtask

  initial begin
    #1 rst_n = 1'b0;
    step(10);
    chk_en = 1'b1;
    lit("reset", 24'h000000, 1'b0, 1'b0);
    rst_n = 1'b1;
    step(5);
    lit("idle_hold", 24'h000000, 1'b0, 1'b0);

    // start: first sampled enable is edge k
    start = 1'b1;
    step(1);
    lit("run_flag", 24'h000000, 1'b1, 1'b0);
    step(3);
    lit("first_tick", 24'h000001, 1'b1, 1'b0);
    step(36);
    lit("cs_ten_carry", 24'h000010, 1'b1, 1'b0);

    // stop with prescaler at 2, then resume
    step(2);
    start = 1'b0;
    step(10);
    lit("stop_frozen", 24'h000010, 1'b0, 1'b0);
    start = 1'b1;
    step(1);
    lit("resume_partial", 24'h000010, 1'b1, 1'b0);
    step(1);
    lit("resume_tick", 24'h000011, 1'b1, 1'b0);

    // clear overrides start
    clr = 1'b1;
    step(10);
    lit("clr_priority", 24'h000000, 1'b0, 1'b0);
    clr = 1'b0;
    step(3);
    lit("restart_wait", 24'h000000, 1'b1, 1'b0);
    step(1);
    lit("restart_tick", 24'h000001, 1'b1, 1'b0);

    // run to 00:59.99, then one tick into the minutes
    step(TD * 5998);
    lit("min_edge", 24'h005999, 1'b1, 1'b0);
    step(TD);
    lit("min_carry", 24'h010000, 1'b1, 1'b0);

    // preload 59:59.99 while stopped, then run through the full wrap
    start = 1'b0;
    step(1);
    chk_en = 1'b0;
    force dut.u_min_ten.dig_q = 4'd5;
    force dut.u_min_one.dig_q = 4'd9;
    force dut.u_sec_ten.dig_q = 4'd5;
    force dut.u_sec_one.dig_q = 4'd9;
    force dut.u_cs_ten.dig_q  = 4'd9;
    force dut.u_cs_one.dig_q  = 4'd9;
    pre_req = 1'b1;
    step(1);
    release dut.u_min_ten.dig_q;
    release dut.u_min_one.dig_q;
    release dut.u_sec_ten.dig_q;
    release dut.u_sec_one.dig_q;
    release dut.u_cs_ten.dig_q;
    release dut.u_cs_one.dig_q;
    pre_req = 1'b0;
    chk_en = 1'b1;
    lit("preload", 24'h595999, 1'b0, 1'b0);
    start = 1'b1;
    step(3);
    lit("pre_wrap", 24'h595999, 1'b1, 1'b0);
    step(1);
    lit("wrap", 24'h000000, 1'b1, 1'b1);
    step(1);
    lit("ovf_one_cycle", 24'h000000, 1'b1, 1'b0);

    // asynchronous reset between edges while running
    step(5);
    #1 rst_n = 1'b0;
    lit("async_reset", 24'h000000, 1'b0, 1'b0);
    step(2);
    rst_n = 1'b1;
    step(3);
    lit("rst_restart_wait", 24'h000000, 1'b1, 1'b0);
    step(1);
    lit("rst_restart_tick", 24'h000001, 1'b1, 1'b0);

    step(2);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
